// File: rtl/ram_arbiter.sv
// ram_arbiter
//
// Two-requester arbiter and sequencer for an 8-bit synchronous single-port
// RAM with registered read data. Port A (Z80 bus) normally has priority and
// port B (loader/DMA) is guaranteed a grant after MAX_WAIT consecutive
// denied cycles. At most one RAM access is issued per clock. Read data is
// returned to the owning port two edges after the transfer edge.
//
// Ports
//   clk, reset                  clock, asynchronous active-high reset
//   a_req/a_we/a_addr/a_wdata   port A request (held until a_gnt)
//   a_gnt                       port A combinational grant
//   a_rdata/a_rvalid            port A read return (rvalid = 1-cycle pulse)
//   b_*                         port B, same as port A
//   ram_ce/ram_wen/ram_addr/ram_wdata   registered RAM command
//   ram_rdata                   RAM registered read data

module ram_arbiter #(
    parameter int ADDR_W   = 17,
    parameter int MAX_WAIT = 3
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [7:0]        a_wdata,
    output logic              a_gnt,
    output logic [7:0]        a_rdata,
    output logic              a_rvalid,

    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [7:0]        b_wdata,
    output logic              b_gnt,
    output logic [7:0]        b_rdata,
    output logic              b_rvalid,

    output logic              ram_ce,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata
);

    localparam int              WCW      = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WCW-1:0]  WAIT_MAX = WCW'(MAX_WAIT);
    localparam bit              FAIR     = (MAX_WAIT != 0);

    logic [WCW-1:0]    wait_cnt;
    logic              force_b;
    logic              xfer;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [7:0]        win_wdata;

    // Return pipeline: stage 1 is aligned with the RAM command registers,
    // stage 2 with the RAM's registered read data.
    logic s1_rd;
    logic s1_own;    // 0 = port A, 1 = port B
    logic s2_rd;
    logic s2_own;

    // ------------------------------------------------------------------
    // Grant decision
    // ------------------------------------------------------------------
    always_comb begin
        force_b = FAIR && b_req && (wait_cnt == WAIT_MAX);
        a_gnt   = 1'b0;
        b_gnt   = 1'b0;
        if (!reset) begin
            if (force_b) begin
                b_gnt = 1'b1;
            end else if (a_req) begin
                a_gnt = 1'b1;
            end else if (b_req) begin
                b_gnt = 1'b1;
            end
        end
    end

    // Grants only assert with their matching request, so either grant is
    // a transfer.
    assign xfer = a_gnt || b_gnt;

    always_comb begin
        win_we    = a_we;
        win_addr  = a_addr;
        win_wdata = a_wdata;
        if (b_gnt) begin
            win_we    = b_we;
            win_addr  = b_addr;
            win_wdata = b_wdata;
        end
    end

    // ------------------------------------------------------------------
    // B starvation counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (b_gnt) begin
            wait_cnt <= '0;
        end else if (b_req && (wait_cnt != WAIT_MAX)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Issue stage
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_ce    <= 1'b0;
            ram_wen   <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            ram_ce  <= xfer;
            ram_wen <= xfer && win_we;
            // Address and data hold when idle to avoid needless toggling
            // on the RAM pins.
            if (xfer) begin
                ram_addr  <= win_addr;
                ram_wdata <= win_wdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Return pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_rd  <= 1'b0;
            s1_own <= 1'b0;
            s2_rd  <= 1'b0;
            s2_own <= 1'b0;
        end else begin
            s1_rd  <= xfer && !win_we;
            s1_own <= b_gnt;
            s2_rd  <= s1_rd;
            s2_own <= s1_own;
        end
    end

    // ------------------------------------------------------------------
    // Read data capture, per port
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_rdata  <= '0;
            a_rvalid <= 1'b0;
            b_rdata  <= '0;
            b_rvalid <= 1'b0;
        end else begin
            a_rvalid <= s2_rd && !s2_own;
            b_rvalid <= s2_rd && s2_own;
            if (s2_rd && !s2_own) begin
                a_rdata <= ram_rdata;
            end
            if (s2_rd && s2_own) begin
                b_rdata <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: directed scenarios followed by a randomized
// phase, all checked against a transaction-level reference model (shadow
// memory, starvation count, queue of expected read returns).

module tb_ram_arbiter;

    localparam int ADDR_W = 17;
    localparam int MW     = 3;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              a_req, a_we, b_req, b_we;
    logic [ADDR_W-1:0] a_addr, b_addr;
    logic [7:0]        a_wdata, b_wdata;
    logic              a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [7:0]        a_rdata, b_rdata;
    logic              ram_ce, ram_wen;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata;

    ram_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
        .ram_ce(ram_ce), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input logic [ADDR_W-1:0] a);
        return a[7:0] ^ 8'h5C;
    endfunction

    // Behavioural synchronous RAM with registered read data.
    logic [7:0] mem [DEPTH];
    bit         written [DEPTH];
    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_wen) begin
                mem[ram_addr]     <= ram_wdata;
                written[ram_addr] <= 1'b1;
            end else begin
                ram_rdata <= written[ram_addr] ? mem[ram_addr] : init_val(ram_addr);
            end
        end
    end

    // ------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------
    typedef struct {
        int         due;
        bit         port;
        logic [7:0] data;
    } rd_t;

    logic [7:0]        smem [DEPTH];
    rd_t               pend [$];
    int                cyc;
    int                wait_m;
    bit                last_ga, last_gb;
    logic [ADDR_W-1:0] exp_raddr;
    logic [7:0]        exp_rwdata;
    logic [7:0]        exp_ard, exp_brd;

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, want, cyc);
        end
    endtask

    task automatic set_a(input bit r, input bit w, input int ad, input int d);
        a_req = r; a_we = w; a_addr = ADDR_W'(ad); a_wdata = 8'(d);
    endtask

    task automatic set_b(input bit r, input bit w, input int ad, input int d);
        b_req = r; b_we = w; b_addr = ADDR_W'(ad); b_wdata = 8'(d);
    endtask

    task automatic model_xfer(input bit port, input bit we,
                              input logic [ADDR_W-1:0] ad, input logic [7:0] d);
        rd_t e;
        exp_raddr  = ad;
        exp_rwdata = d;
        if (we) begin
            smem[ad] = d;
        end else begin
            e.due  = cyc + 2;
            e.port = port;
            e.data = smem[ad];
            pend.push_back(e);
        end
    endtask

    // One clock cycle. Called at a falling edge with the inputs already set.
    task automatic step();
        bit  fb, ga, gb, exp_ce, exp_wen, exp_av, exp_bv;
        rd_t e;
        #1;
        fb = (MW != 0) && b_req && (wait_m >= MW);
        gb = b_req && (fb || !a_req);
        ga = a_req && !gb;
        chk("a_gnt", a_gnt, ga);
        chk("b_gnt", b_gnt, gb);
        @(posedge clk);
        cyc++;
        if (ga) model_xfer(1'b0, a_we, a_addr, a_wdata);
        if (gb) model_xfer(1'b1, b_we, b_addr, b_wdata);
        if (gb)                        wait_m = 0;
        else if (b_req && wait_m < MW) wait_m++;
        exp_ce  = ga || gb;
        exp_wen = ga ? a_we : (gb ? b_we : 1'b0);
        last_ga = ga;
        last_gb = gb;
        @(negedge clk);
        chk("ram_ce", ram_ce, exp_ce);
        chk("ram_wen", ram_wen, exp_wen);
        chk("ram_addr", ram_addr, exp_raddr);
        chk("ram_wdata", ram_wdata, exp_rwdata);
        exp_av = 1'b0;
        exp_bv = 1'b0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            e = pend.pop_front();
            if (e.port) begin exp_bv = 1'b1; exp_brd = e.data; end
            else        begin exp_av = 1'b1; exp_ard = e.data; end
        end
        chk("a_rvalid", a_rvalid, exp_av);
        chk("b_rvalid", b_rvalid, exp_bv);
        chk("a_rdata", a_rdata, exp_ard);
        chk("b_rdata", b_rdata, exp_brd);
    endtask

    task automatic idle(input int n);
        set_a(0, 0, 0, 0);
        set_b(0, 0, 0, 0);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_a_gnt"}, a_gnt, 0);
        chk({tag, "_b_gnt"}, b_gnt, 0);
        chk({tag, "_ram_ce"}, ram_ce, 0);
        chk({tag, "_ram_wen"}, ram_wen, 0);
        chk({tag, "_ram_addr"}, ram_addr, 0);
        chk({tag, "_ram_wdata"}, ram_wdata, 0);
        chk({tag, "_a_rvalid"}, a_rvalid, 0);
        chk({tag, "_b_rvalid"}, b_rvalid, 0);
        chk({tag, "_a_rdata"}, a_rdata, 0);
        chk({tag, "_b_rdata"}, b_rdata, 0);
    endtask

    task automatic model_reset();
        pend.delete();
        wait_m     = 0;
        exp_raddr  = '0;
        exp_rwdata = '0;
        exp_ard    = '0;
        exp_brd    = '0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) smem[i] = init_val(ADDR_W'(i));
        cyc = 0;
        model_reset();
        reset = 1'b1;
        set_a(1, 0, 0, 0);
        set_b(1, 0, 0, 0);
        @(negedge clk);
        #1;
        chk_reset_outputs("por");
        @(negedge clk);
        reset = 1'b0;
        idle(2);

        // Preload read targets through port B.
        set_b(1, 1, 'h0001, 'h11); step();
        set_b(1, 1, 'h0002, 'h22); step();
        set_b(1, 1, 'h0100, 'hA0); step();
        set_b(1, 1, 'h0101, 'hA1); step();
        set_b(1, 1, 'h0102, 'hA2); step();
        idle(1);

        // A writes then reads the same address on the next cycle.
        set_a(1, 1, 'h0010, 'h5A); step();
        set_a(1, 0, 'h0010, 0);    step();
        idle(3);
        chk("raw_a_rdata", a_rdata, 'h5A);

        // Simultaneous single-cycle requests: A first, B the cycle after.
        set_a(1, 0, 'h0001, 0);
        set_b(1, 0, 'h0002, 0);
        step();
        chk("simul_first_a", last_ga, 1);
        set_a(0, 0, 0, 0);
        step();
        chk("simul_then_b", last_gb, 1);
        idle(3);
        chk("simul_a_data", a_rdata, 'h11);
        chk("simul_b_data", b_rdata, 'h22);

        // Continuous contention: A,A,A,B repeating.
        for (int i = 0; i < 12; i++) begin
            set_a(1, 0, 'h0100 + (i % 3), 0);
            set_b(1, 0, 'h0001 + (i % 2), 0);
            step();
            chk("pattern_b", last_gb, (i % 4) == 3);
        end
        idle(3);

        // Back-to-back A reads.
        for (int i = 0; i < 3; i++) begin
            set_a(1, 0, 'h0100 + i, 0);
            step();
        end
        idle(3);
        chk("b2b_last", a_rdata, 'hA2);

        // Reset one cycle after a B read transfer drops the read.
        set_b(1, 0, 'h0002, 0); step();
        idle(1);
        reset = 1'b1;
        set_a(1, 0, 'h0003, 0);
        set_b(1, 0, 'h0004, 0);
        #1;
        chk_reset_outputs("mid");
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("hold");
        reset = 1'b0;
        model_reset();
        idle(4);

        // B write then A read of the same address.
        set_b(1, 1, 'h3FFF, 'h77); step();
        set_b(0, 0, 0, 0);
        set_a(1, 0, 'h3FFF, 0);    step();
        idle(3);
        chk("b_wr_a_rd", a_rdata, 'h77);

        // Randomized traffic; requests hold until granted.
        set_a(0, 0, 0, 0);
        set_b(0, 0, 0, 0);
        last_ga = 1'b0;
        last_gb = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (!a_req || last_ga)
                set_a($urandom_range(0, 99) < 60, $urandom_range(0, 1),
                      'h0200 + $urandom_range(0, 15), $urandom_range(0, 255));
            if (!b_req || last_gb)
                set_b($urandom_range(0, 99) < 70, $urandom_range(0, 1),
                      'h0200 + $urandom_range(0, 15), $urandom_range(0, 255));
            step();
        end
        idle(4);
        chk("drain", pend.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
